framebuffer_writer: RTL
=======================

# framebuffer_writer

Consumes the pixel stream produced by the triangle rasteriser and writes each pixel's colour into the framebuffer in SDRAM through an Avalon-MM write master. Pixels are buffered in an internal show-ahead FIFO. The block drives the rasteriser's `pixel_fifo_full` stall input, clips pixels that fall outside the screen, and converts (x, y) to a linear byte address. It is the last GPU stage before the memory interconnect.

## Interface
- `FIFO_DEPTH`, 16: pixel FIFO entries; power of two, ≥ 4.
- `FB_WIDTH`, 640: screen width in pixels.
- `FB_HEIGHT`, 480: screen height in pixels.
- `clock`  in  1  system clock, shared with the rasteriser.
- `reset_n`  in  1  reset, synchronous, active-low.
- `pixel_data`  in  64  pixel from the rasteriser: [63:48] x, [47:32] y (unsigned), [31:0] colour ARGB8888.
- `pixel_data_valid`  in  1  `pixel_data` is valid this cycle.
- `pixel_fifo_full`  out  1  stall request to the rasteriser.
- `fb_base`  in  32  framebuffer byte base address; quasi-static.
- `avm_address`  out  32  Avalon byte address.
- `avm_write`  out  1  Avalon write request.
- `avm_writedata`  out  32  colour to write.
- `avm_byteenable`  out  4  constant 4'hF.
- `avm_waitrequest`  in  1  Avalon slave stall.
- `idle`  out  1  FIFO empty and no write outstanding.
- `overflow`  out  1  sticky: a pixel arrived while the FIFO was completely full and was dropped.
- `pixels_written`  out  32  count of completed Avalon writes; wraps.
- `pixels_clipped`  out  16  count of discarded out-of-range pixels; saturates at 16'hFFFF.

## Operation
- **FIFO**
  - Push when `pixel_data_valid` is high and count < `FIFO_DEPTH`.
  - If `pixel_data_valid` is high and count == `FIFO_DEPTH`, the pixel is dropped and `overflow` is set.
  - Push and pop in the same cycle leave count unchanged.
- **Stall**
  - `pixel_fifo_full` = (count ≥ `FIFO_DEPTH` − 2), registered from the next-state count.
  - The two spare entries absorb pixels the rasteriser emits after it samples the stall.
- **Clipping**
  - Clip if x ≥ `FB_WIDTH` or y ≥ `FB_HEIGHT`, comparing the full 16-bit fields.
  - A clipped head is popped with no Avalon traffic, at a cost of 1 cycle, and `pixels_clipped` increments.
- **Address**
  - offset = y × `FB_WIDTH` + x, computed 32-bit unsigned.
  - `avm_address` = `fb_base` + (offset << 2), modulo 2^32.
  - `fb_base` is sampled when each pixel is loaded.
- **FSM**
  - S_IDLE:
    - FIFO empty: stay.
    - Head clipped: pop, stay.
    - Head in range: pop; register address and colour; `avm_write` ← 1; go to S_WRITE.
  - S_WRITE: hold `avm_address`, `avm_writedata`, `avm_write` stable while `avm_waitrequest` = 1. When `avm_waitrequest` = 0, the write completes and `pixels_written` increments. Then:
    - Head in range: pop and load it in the same cycle (back-to-back); stay in S_WRITE.
    - Head clipped: pop it; `avm_write` ← 0; go to S_IDLE.
    - FIFO empty: `avm_write` ← 0; go to S_IDLE.
- `idle` = FIFO empty and state S_IDLE.

## Timing
- **Reset** (sampled on the rising edge with `reset_n` = 0)
  - FIFO count, counters and `overflow` go to 0.
  - State goes to S_IDLE.
  - `avm_write` = 0, `avm_address` = 0, `avm_writedata` = 0.
  - `pixel_fifo_full` = 0, `idle` = 1.
  - Reset mid-write drops `avm_write` on the next edge and abandons the transfer. This is accepted; the interconnect is reset on the same signal.
- **Latency:** a pixel pushed at edge N, into an empty FIFO in S_IDLE, has `avm_write` = 1 after edge N+1.
- **Throughput:** one write per cycle while `avm_waitrequest` = 0 and the FIFO stays non-empty.
- **Stall:** `pixel_fifo_full` reflects count after the same edge that changed it.
- **Counters:** `pixels_written` updates on the edge where the write completes. `pixels_clipped` updates on the edge of the clip pop.

## Test plan
- **Single pixel.** `fb_base` = 0x1000_0000; push x=10, y=2, colour 0xFF00FF00 with `avm_waitrequest` = 0.
  - `avm_write` asserts with address 0x1000_1428 (0x10000000 + 1290×4) and data 0xFF00FF00 for exactly 1 cycle.
  - `pixels_written` = 1; `idle` returns to 1.
- **Clipping.** Push (640,0), (0,480), (0xFFFF,5), then (639,479).
  - `pixels_clipped` = 3.
  - Exactly one write, to `fb_base` + 0x12BFFC.
- **Waitrequest hold.** Hold `avm_waitrequest` = 1 for 5 cycles during a write.
  - Address, data and `avm_write` stay stable throughout.
  - The write completes on the first cycle with `avm_waitrequest` low.
- **Backpressure.** Hold `avm_waitrequest` = 1; push pixels every cycle.
  - `pixel_fifo_full` rises when count reaches 14.
  - With 2 more pushes after the rise, no drop occurs and `overflow` stays 0.
  - A 3rd extra push is dropped and sets `overflow`.
- **Streaming.** Push 100 in-range pixels back-to-back with `avm_waitrequest` = 0.
  - 100 writes in order with correct addresses.
  - Consecutive writes occur on consecutive cycles.
- **Reset mid-operation.** Assert `reset_n` = 0 for 1 cycle while 8 pixels are queued and a write is stalled.
  - `avm_write` = 0 next cycle; FIFO empty; `idle` = 1; counters = 0.
  - No queued pixel is written afterwards.

Source files
------------

// File: rtl/framebuffer_writer.sv
// framebuffer_writer
//   Last GPU stage before the memory interconnect. Buffers rasteriser pixels
//   in a show-ahead FIFO, discards pixels outside the screen, converts (x, y)
//   to a linear byte address and writes the colour through an Avalon-MM
//   write master.
//
// Ports
//   clock, reset_n          system clock; synchronous active-low reset
//   pixel_data[63:0]        {x[15:0], y[15:0], colour ARGB8888}
//   pixel_data_valid        pixel_data valid this cycle
//   pixel_fifo_full         stall request to the rasteriser (count >= DEPTH-2)
//   fb_base[31:0]           framebuffer byte base, sampled when a pixel loads
//   avm_address/write/writedata/byteenable, avm_waitrequest   Avalon-MM master
//   idle                    FIFO empty and no write outstanding
//   overflow                sticky: a pixel arrived with the FIFO full
//   pixels_written[31:0]    completed writes, wraps
//   pixels_clipped[15:0]    discarded pixels, saturates
//   dbg_state_o             FSM state for observation (1 = write in flight)
//
// Handshake: the Avalon write is presented with avm_write = 1 and its address
// and data held stable; it completes on a rising edge where avm_write = 1 and
// avm_waitrequest = 0. pixel_data is accepted on any edge with
// pixel_data_valid = 1 unless the FIFO is completely full, in which case the
// pixel is dropped.
module framebuffer_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] pixel_data,
  input  logic        pixel_data_valid,
  output logic        pixel_fifo_full,
  input  logic [31:0] fb_base,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        idle,
  output logic        overflow,
  output logic [31:0] pixels_written,
  output logic [15:0] pixels_clipped,
  output logic        dbg_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [63:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q;
  logic               overflow_q;
  logic [31:0]        addr_q, data_q;
  logic [31:0]        written_q;
  logic [15:0]        clipped_q;

  logic               push, drop, pop, load, clip_pop, wr_done;
  logic               fifo_empty;
  logic [63:0]        head;
  logic [15:0]        head_x, head_y;
  logic               head_clip;
  logic [31:0]        offset;
  logic [31:0]        addr_d;

  assign fifo_empty = (count_q == '0);
  assign push       = pixel_data_valid && (count_q != CNT_W'(FIFO_DEPTH));
  assign drop       = pixel_data_valid && (count_q == CNT_W'(FIFO_DEPTH));

  // Show-ahead: the head entry is visible before it is popped.
  assign head      = mem_q[rd_ptr_q];
  assign head_x    = head[63:48];
  assign head_y    = head[47:32];
  assign head_clip = (32'(head_x) >= 32'(FB_WIDTH)) || (32'(head_y) >= 32'(FB_HEIGHT));
  assign offset    = 32'(head_y) * 32'(FB_WIDTH) + 32'(head_x);
  assign addr_d    = fb_base + (offset << 2);

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // Next-state and pop control. A write in flight only frees the bus when
  // waitrequest is low; the head can then be loaded in the same cycle.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load     = 1'b0;
    clip_pop = 1'b0;
    wr_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_clip) begin
            clip_pop = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
          wr_done = 1'b1;
          if (fifo_empty) begin
            state_d = S_IDLE;
          end else begin
            pop = 1'b1;
            if (head_clip) begin
              clip_pop = 1'b1;
              state_d  = S_IDLE;
            end else begin
              load = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage needs no reset; only the pointers and count define content.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= pixel_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      written_q  <= '0;
      clipped_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      // Two spare entries cover pixels emitted after the stall is sampled.
      full_q  <= (count_d >= CNT_W'(FIFO_DEPTH - 2));
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
      if (load) begin
        addr_q <= addr_d;
        data_q <= head[31:0];
      end
      if (wr_done) written_q <= written_q + 32'd1;
      if (clip_pop && (clipped_q != 16'hFFFF)) clipped_q <= clipped_q + 16'd1;
    end
  end

  assign pixel_fifo_full = full_q;
  assign avm_address     = addr_q;
  assign avm_writedata   = data_q;
  assign avm_write       = (state_q == S_WRITE);
  assign avm_byteenable  = 4'hF;
  assign idle            = fifo_empty && (state_q == S_IDLE);
  assign overflow        = overflow_q;
  assign pixels_written  = written_q;
  assign pixels_clipped  = clipped_q;
  assign dbg_state_o     = state_q;

endmodule
